// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: control-period states, guard-band symbols,
// preamble control word and default 640x480 raster timing.
package hdmi_pkg;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    ACTIVE   = 2'd3
  } period_e;

  // Fixed video guard-band TMDS symbols substituted by the top level.
  localparam logic [9:0] GB_CODE_CH0 = 10'b1011001100;
  localparam logic [9:0] GB_CODE_CH1 = 10'b0100110011;
  localparam logic [9:0] GB_CODE_CH2 = 10'b1011001100;

  localparam logic [1:0] PREAMBLE_CTL = 2'b01;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster h/v counters with polarity-adjusted syncs and a look-ahead flag
// telling whether the following line carries active video.
module hdmi_timing_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          next_active
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_START = HW'(H_ACTIVE);
  localparam logic          HS_LVL  = (HS_POL != 0);
  localparam logic          VS_LVL  = (VS_POL != 0);

  logic [VW-1:0] vcount_nxt;
  logic          hs_act;
  logic          vs_act;

  // Reset parks the raster mid-way through the last blanking line so the
  // first frame still gets a complete preamble and guard band.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= H_START;
      vcount <= V_LAST;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= vcount_nxt;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_comb begin
    vcount_nxt  = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    next_active = int'(vcount_nxt) < V_ACTIVE;
    hs_act      = (int'(hcount) >= H_ACTIVE + H_FP) &&
                  (int'(hcount) <  H_ACTIVE + H_FP + H_SYNC);
    vs_act      = (int'(vcount) >= V_ACTIVE + V_FP) &&
                  (int'(vcount) <  V_ACTIVE + V_FP + V_SYNC);
    hsync       = hs_act ~^ HS_LVL;
    vsync       = vs_act ~^ VS_LVL;
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel period decode (control / preamble / guard / video) driving the
// three TMDS encoders through one register stage.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_rgb,
  output logic        pix_req,
  output logic [7:0]  vd0,
  output logic [7:0]  vd1,
  output logic [7:0]  vd2,
  output logic [1:0]  cd0,
  output logic [1:0]  cd1,
  output logic [1:0]  cd2,
  output logic        vde,
  output logic        gb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [1:0] CD0_IDLE = {(VS_POL == 0), (HS_POL == 0)};

  // A short back porch would let hsync overlap the preamble window.
  if (H_BP < 10) begin : g_bad_hbp
    $error("hdmi_period_scheduler: H_BP must be at least 10");
  end

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          next_active;
  period_e       period;
  logic [23:0]   vd_n;
  logic [1:0]    cd0_n;
  logic [1:0]    cd1_n;
  logic          vde_n;
  logic          gb_n;
  logic          fs_n;

  hdmi_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .next_active(next_active)
  );

  always_comb begin
    period = CTRL;
    if (int'(hcount) < H_ACTIVE && int'(vcount) < V_ACTIVE) begin
      period = ACTIVE;
    end else if (next_active && int'(hcount) >= H_TOTAL - 10) begin
      period = (int'(hcount) >= H_TOTAL - 2) ? GUARD : PREAMBLE;
    end
  end

  always_comb begin
    vd_n  = '0;
    cd0_n = {vsync, hsync};
    cd1_n = 2'b00;
    vde_n = 1'b0;
    gb_n  = 1'b0;
    fs_n  = 1'b0;
    case (period)
      ACTIVE: begin
        vde_n = 1'b1;
        vd_n  = pix_rgb;
        fs_n  = (hcount == '0) && (vcount == '0);
      end
      PREAMBLE: cd1_n = PREAMBLE_CTL;
      GUARD: begin
        cd1_n = PREAMBLE_CTL;
        gb_n  = 1'b1;
      end
      default: ;
    endcase
  end

  assign pix_req = (period == ACTIVE) && !rst;
  assign cd2     = 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      vd2         <= '0;
      vd1         <= '0;
      vd0         <= '0;
      cd0         <= CD0_IDLE;
      cd1         <= '0;
      vde         <= 1'b0;
      gb          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vd2         <= vd_n[23:16];
      vd1         <= vd_n[15:8];
      vd0         <= vd_n[7:0];
      cd0         <= cd0_n;
      cd1         <= cd1_n;
      vde         <= vde_n;
      gb          <= gb_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Randomized bench for hdmi_period_scheduler on a tiny raster, with both sync
// polarities, checked against a raster model built from plain arithmetic.
module tb_hdmi_period_scheduler;

  localparam int HA = 4, HF = 2, HS = 3, HB = 12;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct {
    logic [7:0] vd0, vd1, vd2;
    logic [1:0] cd0, cd1;
    logic       vde, gb, fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_rgb = '0;

  logic       a_req, b_req;
  logic [7:0] a_vd0, a_vd1, a_vd2, b_vd0, b_vd1, b_vd2;
  logic [1:0] a_cd0, a_cd1, a_cd2, b_cd0, b_cd1, b_cd2;
  logic       a_vde, a_gb, a_fs, b_vde, b_gb, b_fs;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_h = 0, m_v = 0, cyc = 0;
  bit   trk = 0;
  int   last_fs = -1, vde_cnt = 0, n_fs = 0;
  exp_t e_a, e_b;

  always #5 clk = ~clk;

  hdmi_period_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_rgb(pix_rgb), .pix_req(a_req),
    .vd0(a_vd0), .vd1(a_vd1), .vd2(a_vd2),
    .cd0(a_cd0), .cd1(a_cd1), .cd2(a_cd2),
    .vde(a_vde), .gb(a_gb), .frame_start(a_fs)
  );

  hdmi_period_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_rgb(pix_rgb), .pix_req(b_req),
    .vd0(b_vd0), .vd1(b_vd1), .vd2(b_vd2),
    .cd0(b_cd0), .cd1(b_cd1), .cd2(b_cd2),
    .vde(b_vde), .gb(b_gb), .frame_start(b_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected registered outputs for one raster position.
  function automatic exp_t model(input int h, input int v, input bit r,
                                 input logic [23:0] px, input bit pol);
    exp_t x;
    bit act, na, pre, grd, hs_on, vs_on;
    x.vd0 = '0; x.vd1 = '0; x.vd2 = '0;
    x.cd1 = '0; x.vde = 0; x.gb = 0; x.fs = 0;
    x.cd0 = {~pol, ~pol};
    if (r) return x;
    act   = (h < HA) && (v < VA);
    na    = ((v + 1) % VT) < VA;
    pre   = na && (h >= HT - 10) && (h < HT - 2);
    grd   = na && (h >= HT - 2);
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    x.cd0 = {vs_on ? pol : ~pol, hs_on ? pol : ~pol};
    x.cd1 = (pre || grd) ? 2'b01 : 2'b00;
    x.gb  = grd;
    x.vde = act;
    x.fs  = act && (h == 0) && (v == 0);
    if (act) begin
      x.vd2 = px[23:16];
      x.vd1 = px[15:8];
      x.vd0 = px[7:0];
    end
    return x;
  endfunction

  task automatic step();
    bit exp_req;
    @(posedge clk);
    e_a = model(m_h, m_v, rst, pix_rgb, 1'b0);
    e_b = model(m_h, m_v, rst, pix_rgb, 1'b1);
    if (rst) begin
      m_h = HA;
      m_v = VT - 1;
    end else begin
      m_h = (m_h + 1) % HT;
      if (m_h == 0) m_v = (m_v + 1) % VT;
    end
    cyc++;
    @(negedge clk);
    exp_req = !rst && (m_h < HA) && (m_v < VA);
    check("a_vd", {a_vd2, a_vd1, a_vd0}, {e_a.vd2, e_a.vd1, e_a.vd0});
    check("a_cd0", a_cd0, e_a.cd0);
    check("a_cd1", a_cd1, e_a.cd1);
    check("a_cd2", a_cd2, 2'b00);
    check("a_vde", a_vde, e_a.vde);
    check("a_gb", a_gb, e_a.gb);
    check("a_fs", a_fs, e_a.fs);
    check("a_pix_req", a_req, exp_req);
    check("b_vd", {b_vd2, b_vd1, b_vd0}, {e_b.vd2, e_b.vd1, e_b.vd0});
    check("b_cd0", b_cd0, e_b.cd0);
    check("b_cd1", b_cd1, e_b.cd1);
    check("b_vde_gb_fs", {b_vde, b_gb, b_fs}, {e_b.vde, e_b.gb, e_b.fs});
    check("b_pix_req", b_req, exp_req);
    if (trk) begin
      if (b_fs) begin
        if (last_fs >= 0) begin
          check("fs_interval", cyc - last_fs, HT * VT);
          check("vde_per_frame", vde_cnt, HA * VA);
        end
        last_fs = cyc;
        vde_cnt = 0;
        n_fs++;
      end
      if (b_vde) vde_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_rgb = $urandom;
    step();
    step();
    rst = 1'b0;
    step();
    check("cyc1_cd0", a_cd0, 2'b11);
    check("cyc1_vde", a_vde, 1'b0);

    // Three undisturbed frames with random pixels, tracking frame cadence.
    trk = 1;
    for (int i = 0; i < 3 * HT * VT + 30; i++) begin
      pix_rgb = $urandom;
      step();
    end
    trk = 0;
    check("fs_count", (n_fs >= 3), 1'b1);

    // Constant pixel across a full frame.
    pix_rgb = 24'hAABBCC;
    for (int i = 0; i < HT * VT; i++) step();

    // One-cycle reset in the middle of an active line.
    for (int i = 0; i < 2 * HT * VT && !(m_v == 0 && m_h == 2); i++) begin
      pix_rgb = $urandom;
      step();
    end
    check("reach_mid_line", (m_v == 0 && m_h == 2), 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_req", a_req, 1'b0);
    rst = 1'b0;
    step();
    check("mid_rst_vde", {a_vde, b_vde}, 2'b00);
    check("mid_rst_cd0", {a_cd0, b_cd0}, 4'b1100);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      pix_rgb = $urandom;
      step();
    end

    // Random pixels with occasional reset pulses.
    for (int i = 0; i < 2500; i++) begin
      pix_rgb = $urandom;
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
